// File: rtl/sha3_pad_blk.sv
// Sponge input formatter: turns a byte-granular 64-bit message stream into
// Keccak-f[1600] state blocks with multi-rate padding and a domain suffix.
module sha3_pad_blk #(
    parameter int         RATE_LANES  = 17,
    parameter logic [7:0] DSUFFIX     = 8'h06,
    parameter int         STATE_LANES = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pushin,
    output logic        stopin,
    input  logic        lastin,
    input  logic [3:0]  nbytes,
    input  logic [63:0] din,
    output logic        pushout,
    input  logic        stopout,
    output logic        firstout,
    output logic        lastout,
    output logic [63:0] dout
);

    localparam logic [2:0]  S_IDLE = 3'd0;
    localparam logic [2:0]  S_DATA = 3'd1;
    localparam logic [2:0]  S_PAD  = 3'd2;
    localparam logic [2:0]  S_ZERO = 3'd3;
    localparam logic [2:0]  S_XBLK = 3'd4;

    localparam logic [4:0]  LAST_RATE = 5'(RATE_LANES - 1);
    localparam logic [4:0]  LAST_LANE = 5'(STATE_LANES - 1);
    localparam logic [63:0] PAD_HI    = 64'h8000_0000_0000_0000;
    localparam logic [63:0] SUF       = {56'd0, DSUFFIX};

    logic [2:0]  state, state_nx;
    logic [4:0]  lane;
    logic        fin, fin_nx;      // current block is the message's final block
    logic        xpend, xpend_nx;  // an all-padding block must follow this one
    logic        adv, gen, take, load;
    logic [3:0]  nb;
    logic [63:0] keep, sufv, rate_hi, lane_val;
    logic        lane_last;

    assign adv    = !pushout || !stopout;
    assign gen    = (state == S_PAD) || (state == S_ZERO) || (state == S_XBLK);
    assign stopin = (pushout && stopout) || gen;
    assign take   = pushin && !stopin;
    assign load   = take || (gen && adv);

    always_comb begin
        nb = 4'd8;
        if (lastin && nbytes < 4'd8)
            nb = nbytes;
        keep = '1;
        sufv = '0;
        if (nb < 4'd8) begin
            keep = (64'd1 << {nb[2:0], 3'b000}) - 64'd1;
            sufv = SUF << {nb[2:0], 3'b000};
        end
        rate_hi = (lane == LAST_RATE) ? PAD_HI : '0;
    end

    always_comb begin
        state_nx  = state;
        fin_nx    = fin;
        xpend_nx  = xpend;
        lane_val  = '0;
        lane_last = 1'b0;
        case (state)
            S_IDLE, S_DATA: begin
                lane_val = din;
                if (take) begin
                    if (!lastin) begin
                        state_nx = (lane == LAST_RATE) ? S_ZERO : S_DATA;
                    end else if (nb < 4'd8) begin
                        lane_val = (din & keep) | sufv | rate_hi;
                        fin_nx   = 1'b1;
                        state_nx = S_ZERO;
                    end else if (lane == LAST_RATE) begin
                        // rate filled exactly: close this block, then a padding-only block
                        xpend_nx = 1'b1;
                        state_nx = S_ZERO;
                    end else begin
                        fin_nx   = 1'b1;
                        state_nx = S_PAD;
                    end
                end
            end
            S_PAD, S_XBLK: begin
                lane_val = SUF | rate_hi;
                if (adv)
                    state_nx = S_ZERO;
            end
            S_ZERO: begin
                // zero fill for the rest of the rate (final block only) and all capacity lanes
                lane_val  = fin ? rate_hi : '0;
                lane_last = fin && (lane == LAST_LANE);
                if (adv && lane == LAST_LANE) begin
                    if (xpend) begin
                        xpend_nx = 1'b0;
                        fin_nx   = 1'b1;
                        state_nx = S_XBLK;
                    end else begin
                        fin_nx   = 1'b0;
                        state_nx = fin ? S_IDLE : S_DATA;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            lane     <= '0;
            fin      <= 1'b0;
            xpend    <= 1'b0;
            pushout  <= 1'b0;
            firstout <= 1'b0;
            lastout  <= 1'b0;
            dout     <= '0;
        end else begin
            state <= state_nx;
            fin   <= fin_nx;
            xpend <= xpend_nx;
            if (load) begin
                dout     <= lane_val;
                pushout  <= 1'b1;
                firstout <= (lane == 5'd0);
                lastout  <= lane_last;
                lane     <= (lane == LAST_LANE) ? 5'd0 : lane + 5'd1;
            end else if (adv) begin
                pushout  <= 1'b0;
                firstout <= 1'b0;
                lastout  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sha3_pad_blk.sv
// Random and directed stimulus for sha3_pad_blk across several rates, checked
// against a byte-level Keccak padding model.
`timescale 1ns/1ps
module tb_sha3_pad_blk;

    localparam int NI = 4;
    localparam int         RL [NI] = '{17, 9, 1, 21};
    localparam logic [7:0] DS [NI] = '{8'h06, 8'h06, 8'h06, 8'h1F};

    typedef logic [7:0] u8;
    typedef struct packed { logic [63:0] d; logic f; logic l; } lane_t;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic [NI-1:0]         pushin = '0, lastin = '0, stopout = '0;
    logic [NI-1:0][3:0]    nbytes = '0;
    logic [NI-1:0][63:0]   din = '0;
    wire  [NI-1:0]         stopin, pushout, firstout, lastout;
    wire  [NI-1:0][63:0]   dout;

    int    smode [NI];
    lane_t exp_q [NI][$];
    int    cons  [NI];
    lane_t hv    [NI];
    logic [NI-1:0] held = '0;
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sha3_pad_blk #(.RATE_LANES(RL[g]), .DSUFFIX(DS[g]), .STATE_LANES(25)) dut (
            .clk(clk), .reset(reset), .pushin(pushin[g]), .stopin(stopin[g]),
            .lastin(lastin[g]), .nbytes(nbytes[g]), .din(din[g]),
            .pushout(pushout[g]), .stopout(stopout[g]), .firstout(firstout[g]),
            .lastout(lastout[g]), .dout(dout[g])
        );
    end

    task automatic chk(int k, string nm, logic [127:0] act, logic [127:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s inst %0d: got %h, expected %h", nm, k, act, expv);
        end
    endtask

    // Padded message as bytes, cut into blocks of rate bytes, capacity appended as zero lanes.
    task automatic model(int k, input u8 m[$]);
        int rb, n, nblk;
        u8 p[$];
        lane_t e;
        rb = RL[k] * 8;
        n = m.size();
        nblk = n / rb + 1;
        for (int i = 0; i < nblk * rb; i++) p.push_back(i < n ? m[i] : 8'h00);
        p[n] = p[n] | DS[k];
        p[nblk*rb-1] = p[nblk*rb-1] | 8'h80;
        for (int b = 0; b < nblk; b++)
            for (int l = 0; l < 25; l++) begin
                e.d = '0;
                if (l < RL[k])
                    for (int by = 0; by < 8; by++) e.d[8*by +: 8] = p[b*rb + l*8 + by];
                e.f = (l == 0);
                e.l = (b == nblk - 1) && (l == 24);
                exp_q[k].push_back(e);
            end
    endtask

    // Called and returns at posedge+1; junk above the valid bytes tests masking.
    task automatic send(int k, input u8 m[$], bit gaps);
        int n, nw, nb, t;
        bit acc, last;
        logic [63:0] d;
        logic [3:0] nbf;
        n = m.size();
        nw = (n == 0) ? 1 : (n + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            last = (w == nw - 1);
            nb = last ? n - 8*w : 8;
            d = {$urandom, $urandom};
            for (int by = 0; by < nb; by++) d[8*by +: 8] = m[8*w + by];
            if (!last)        nbf = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd8;
            else if (nb == 8) nbf = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'd8;
            else              nbf = 4'(nb);
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            pushin[k] = 1'b1; din[k] = d; nbytes[k] = nbf; lastin[k] = last;
            acc = 0; t = 0;
            while (!acc && t < 3000) begin
                @(negedge clk); acc = !stopin[k];
                @(posedge clk); #1; t++;
            end
            pushin[k] = 1'b0; lastin[k] = 1'b0; din[k] = {$urandom, $urandom};
            vectors++;
            if (!acc) begin
                miscompares++;
                $display("FAIL accept_timeout inst %0d: word %0d not accepted, acceptance required", k, w);
                return;
            end
        end
    endtask

    task automatic drain(int k);
        int t;
        t = 0;
        while (exp_q[k].size() != 0 && t < 5000) begin @(posedge clk); #1; t++; end
        vectors++;
        if (exp_q[k].size() != 0) begin
            miscompares++;
            $display("FAIL drain inst %0d: %0d lanes still outstanding, 0 required", k, exp_q[k].size());
        end
    endtask

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < NI; k++)
            case (smode[k])
                0:       stopout[k] = 1'b0;
                1:       stopout[k] = ~stopout[k];
                default: stopout[k] = ($urandom_range(0, 3) == 0);
            endcase
    end

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (!reset) begin
                chk(k, "rst_outputs", {pushout[k], firstout[k], lastout[k], stopin[k]}, 0);
                chk(k, "rst_dout", dout[k], 0);
                held[k] = 1'b0;
            end else begin
                if (held[k])
                    chk(k, "stall_hold", {pushout[k], firstout[k], lastout[k], dout[k]},
                        {1'b1, hv[k].f, hv[k].l, hv[k].d});
                held[k] = pushout[k] && stopout[k];
                if (held[k]) begin
                    chk(k, "stall_stopin", stopin[k], 1);
                    hv[k] = {dout[k], firstout[k], lastout[k]};
                end
                if (pushout[k] && !stopout[k]) begin
                    if (exp_q[k].size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL unexpected_lane inst %0d: got lane %h, no lane expected", k, dout[k]);
                    end else begin
                        lane_t e;
                        e = exp_q[k].pop_front();
                        chk(k, "lane", {firstout[k], lastout[k], dout[k]}, {e.f, e.l, e.d});
                        cons[k]++;
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        u8 m[$];
        int rb, len, t;
        for (int k = 0; k < NI; k++) begin smode[k] = 0; cons[k] = 0; end
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #1;

        // "abc", R=17
        m = '{8'h61, 8'h62, 8'h63};
        model(0, m);
        chk(0, "pin_abc_size", exp_q[0].size(), 25);
        chk(0, "pin_abc_l0", exp_q[0][0].d, 64'h0000000006636261);
        chk(0, "pin_abc_l16", exp_q[0][16].d, 64'h8000000000000000);
        chk(0, "pin_abc_last", {exp_q[0][23].l, exp_q[0][24].l}, 2'b01);
        send(0, m, 0);
        chk(0, "abc_latency", {pushout[0], firstout[0], dout[0]}, {2'b11, 64'h0000000006636261});
        drain(0);

        // empty message
        m.delete();
        model(0, m);
        chk(0, "pin_empty_l0", exp_q[0][0].d, 64'h06);
        chk(0, "pin_empty_l16", exp_q[0][16].d, 64'h8000000000000000);
        send(0, m, 0);
        drain(0);

        // exact rate, R=9: stopin held for all 41 generated lanes
        m.delete();
        for (int i = 0; i < 9; i++) for (int b = 0; b < 8; b++) m.push_back(b == 0 ? u8'(i) : 8'h00);
        model(1, m);
        chk(1, "pin_exact_size", exp_q[1].size(), 50);
        chk(1, "pin_exact_l8", exp_q[1][8].d, 64'd8);
        chk(1, "pin_exact_b1last", exp_q[1][24].l, 0);
        chk(1, "pin_exact_b2l0", exp_q[1][25].d, 64'h06);
        chk(1, "pin_exact_b2l8", exp_q[1][33].d, 64'h8000000000000000);
        send(1, m, 0);
        for (int i = 0; i < 41; i++) begin @(negedge clk); chk(1, "exact_stopin", stopin[1], 1); end
        @(negedge clk); chk(1, "exact_stopin_end", stopin[1], 0);
        @(posedge clk); #1;
        drain(1);

        // merged pad byte, R=1
        m.delete();
        repeat (7) m.push_back(8'hFF);
        model(2, m);
        chk(2, "pin_merge_l0", exp_q[2][0].d, 64'h86FFFFFFFFFFFFFF);
        send(2, m, 0);
        drain(2);

        // backpressure toggling
        smode[0] = 1;
        m = '{8'h61, 8'h62, 8'h63};
        model(0, m);
        send(0, m, 0);
        drain(0);
        smode[0] = 0;

        // randomized messages around block boundaries, random stalls, some back-to-back
        for (int k = 0; k < NI; k++) begin
            rb = RL[k] * 8;
            for (int i = 0; i < 12; i++) begin
                case ($urandom_range(0, 3))
                    0:       len = $urandom_range(0, 2*rb + 9);
                    1:       len = rb * $urandom_range(1, 2);
                    2:       len = rb * $urandom_range(1, 2) - $urandom_range(1, 9);
                    default: len = $urandom_range(0, 8);
                endcase
                if (len < 0) len = 0;
                smode[k] = $urandom_range(0, 1) ? 2 : 0;
                m.delete();
                for (int j = 0; j < len; j++) m.push_back(u8'($urandom));
                model(k, m);
                send(k, m, 1);
                if ($urandom_range(0, 2) == 0) drain(k);
            end
            drain(k);
            smode[k] = 0;
        end

        // reset in the middle of a block, then a clean "abc"
        cons[0] = 0;
        m = '{8'h61, 8'h62, 8'h63};
        model(0, m);
        send(0, m, 0);
        t = 0;
        while (cons[0] < 10 && t < 200) begin @(posedge clk); #2; t++; end
        chk(0, "midrst_reach_lane10", cons[0] >= 10, 1);
        reset = 1'b0;
        exp_q[0].delete();
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        model(0, m);
        send(0, m, 0);
        chk(0, "postrst_l0", {pushout[0], firstout[0], dout[0]}, {2'b11, 64'h0000000006636261});
        drain(0);
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
